// File: rtl/bool_func_pkg.sv
// bool_func_pkg: mode encodings and per-lane output-mode selection for bool_func_pipe
package bool_func_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_NORM = 2'd0;
  localparam mode_t MODE_INV  = 2'd1;
  localparam mode_t MODE_XOR  = 2'd2;
  function automatic logic [1:0] apply_mode(input logic f1, input logic f2, input mode_t mode);
    return mode == MODE_INV ? {~f1, ~f2} : mode == MODE_XOR ? {f1 ^ f2, f2} : {f1, f2};
  endfunction
endpackage

// File: rtl/bool_func_core.sv
// bool_func_core: combinational WIDTH-lane f1/f2 evaluation with output mode applied
module bool_func_core
  import bool_func_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  mode_t            mode,
  output logic [WIDTH-1:0] f1,
  output logic [WIDTH-1:0] f2
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic t2;
    assign t2 = ~a[i] & b[i];
    assign {f1[i], f2[i]} = apply_mode((~b[i] & c[i]) | a[i] | (t2 ^ d[i]), d[i] | t2, mode);
  end
endmodule

// File: rtl/bool_func_pipe.sv
// bool_func_pipe: two-stage valid/ready boolean function pipeline, optional counters under BFP_STATS_EN
module bool_func_pipe
  import bool_func_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f1,
  output logic [WIDTH-1:0] out_f2,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_txn,
  output logic [CNT_W-1:0] cnt_f1
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s2_load, in_hs;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [WIDTH-1:0] f1_q, f1_d, f2_q, f2_d, core_f1, core_f2;
  mode_t            mode_q, mode_d;
  bool_func_core #(.WIDTH(WIDTH)) u_core (
    .a(a_q), .b(b_q), .c(c_q), .d(d_q), .mode(mode_q), .f1(core_f1), .f2(core_f2)
  );
  always_comb begin
    s2_load    = ~s2_valid_q | out_ready;
    in_ready   = ~s1_valid_q | s2_load;
    in_hs      = in_valid & in_ready;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    a_d        = in_hs ? in_a : a_q;
    b_d        = in_hs ? in_b : b_q;
    c_d        = in_hs ? in_c : c_q;
    d_d        = in_hs ? in_d : d_q;
    mode_d     = in_hs ? in_mode : mode_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    f1_d       = s2_load & s1_valid_q ? core_f1 : f1_q;
    f2_d       = s2_load & s1_valid_q ? core_f2 : f2_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      mode_q     <= MODE_NORM;
      f1_q       <= '0;
      f2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      mode_q     <= mode_d;
      f1_q       <= f1_d;
      f2_q       <= f2_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign out_f1    = f1_q;
  assign out_f2    = f2_q;
`ifdef BFP_STATS_EN
  logic             out_hs;
  logic [CNT_W-1:0] cnt_txn_q, cnt_txn_d, cnt_f1_q, cnt_f1_d;
  always_comb begin
    out_hs    = s2_valid_q & out_ready;
    cnt_txn_d = stats_clr ? '0 : cnt_txn_q + CNT_W'(out_hs);
    cnt_f1_d  = stats_clr ? '0 : out_hs ? cnt_f1_q + CNT_W'($countones(f1_q)) : cnt_f1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_txn_q <= '0;
      cnt_f1_q  <= '0;
    end else begin
      cnt_txn_q <= cnt_txn_d;
      cnt_f1_q  <= cnt_f1_d;
    end
  end
  assign cnt_txn = cnt_txn_q;
  assign cnt_f1  = cnt_f1_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign cnt_txn = '0;
  assign cnt_f1  = '0;
`endif
endmodule

// File: tb/tb_bool_func_pipe.sv
// tb_bool_func_pipe: randomized and directed checks of bool_func_pipe against a behavioural model
module tb_bool_func_pipe;
  localparam int W = 4;
  localparam int CW = 32;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b1, stats_clr = 1'b0;
  logic          in_ready, out_valid;
  logic [W-1:0]  in_a = '0, in_b = '0, in_c = '0, in_d = '0, out_f1, out_f2;
  logic [1:0]    in_mode = 2'd0;
  logic [CW-1:0] cnt_txn, cnt_f1;
  int            n_chk = 0, n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic          held = 1'b0;
  logic [W-1:0]  held_f1, held_f2;
  logic [CW-1:0] m_txn = '0, m_f1 = '0;
  logic [W-1:0]  tv_a[6]  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
  logic [W-1:0]  tv_b[6]  = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0000};
  logic [W-1:0]  tv_c[6]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
  logic [W-1:0]  tv_d[6]  = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
  logic [1:0]    tv_m[6]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
  logic [W-1:0]  tv_f1[6] = '{4'b1110, 4'b0001, 4'b1001, 4'b1110, 4'b1111, 4'b0000};
  logic [W-1:0]  tv_f2[6] = '{4'b0111, 4'b1000, 4'b0111, 4'b0111, 4'b1111, 4'b0000};

  bool_func_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_f1(out_f1), .out_f2(out_f2),
    .stats_clr(stats_clr), .cnt_txn(cnt_txn), .cnt_f1(cnt_f1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_f(input logic [W-1:0] a, b, c, d, input logic [1:0] m);
    logic [W-1:0] f1, f2;
    f2 = d | (~a & b);
    f1 = (~b & c) | a | ((~a & b) ^ d);
    case (m)
      2'd1:    return {~f1, ~f2};
      2'd2:    return {f1 ^ f2, f2};
      default: return {f1, f2};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held  = 1'b0;
      m_txn = '0;
      m_f1  = '0;
    end else begin
      logic [2*W-1:0] e;
      e = '0;
      if (held) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_f1", 32'(out_f1), 32'(held_f1));
        chk("hold_f2", 32'(out_f2), 32'(held_f2));
      end
      if (out_valid && out_ready) begin
        chk("out_not_spurious", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data_f1", 32'(out_f1), 32'(e[2*W-1:W]));
          chk("data_f2", 32'(out_f2), 32'(e[W-1:0]));
        end
      end
      if (stats_clr) begin
        m_txn = '0;
        m_f1  = '0;
      end else if (out_valid && out_ready) begin
        m_txn = m_txn + 1;
        m_f1  = m_f1 + CW'($countones(e[2*W-1:W]));
      end
      held    = out_valid && !out_ready;
      held_f1 = out_f1;
      held_f2 = out_f2;
      if (in_valid && in_ready) exp_q.push_back(ref_f(in_a, in_b, in_c, in_d, in_mode));
    end
  end

  task automatic send_one(input int k);
    int lat;
    in_valid = 1'b1;
    in_a = tv_a[k]; in_b = tv_b[k]; in_c = tv_c[k]; in_d = tv_d[k]; in_mode = tv_m[k];
    chk("dir_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("dir_lat_%0d", k), lat, 2);
    chk($sformatf("dir_f1_%0d", k), 32'(out_f1), 32'(tv_f1[k]));
    chk($sformatf("dir_f2_%0d", k), 32'(out_f2), 32'(tv_f2[k]));
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((out_valid || exp_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 32'(out_valid || exp_q.size() != 0), 0);
  endtask

  task automatic rand_in();
    in_a = W'($urandom); in_b = W'($urandom); in_c = W'($urandom); in_d = W'($urandom);
    in_mode = 2'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_f1", 32'(out_f1), 0);
    chk("rst_f2", 32'(out_f2), 0);
    chk("rst_cnt_txn", cnt_txn, 0);
    for (int k = 0; k < 6; k++) send_one(k);
    drain();
    for (int i = 0; i < 8; i++) begin
      rand_in();
      in_valid = 1'b1;
      chk("stream_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      chk("stream_out_valid", 32'(out_valid), 32'(i >= 1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_tail_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    chk("stream_tail_empty", 32'(out_valid), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_in();
      in_valid = 1'b1;
      chk("bp_in_ready", 32'(in_ready), 32'(i < 2));
      @(posedge clk); #1;
    end
    drain();
    for (int i = 0; i < 400; i++) begin
      rand_in();
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      stats_clr = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    stats_clr = 1'b0;
    drain();
    @(posedge clk); #1;
`ifdef BFP_STATS_EN
    chk("rand_cnt_txn", cnt_txn, m_txn);
    chk("rand_cnt_f1", cnt_f1, m_f1);
`else
    chk("nostats_cnt_txn", cnt_txn, 0);
    chk("nostats_cnt_f1", cnt_f1, 0);
`endif
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_in();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_f1", 32'(out_f1), 0);
    chk("midrst_f2", 32'(out_f2), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_old", 32'(out_valid), 0);
    end
    send_one(0);
    send_one(1);
    send_one(4);
    @(posedge clk); #1;
`ifdef BFP_STATS_EN
    chk("stats_txn3", cnt_txn, 3);
    chk("stats_f1_8", cnt_f1, 8);
`endif
    send_one(2);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    chk("clr_consumed", 32'(out_valid), 0);
    chk("clr_cnt_txn", cnt_txn, 0);
    chk("clr_cnt_f1", cnt_f1, 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
